// File: rtl/tmds_pkg.sv
// Shared TMDS constants, disparity type and helpers for the pixel-domain encoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_00    = 10'b1101010100;
    localparam logic [9:0] CTRL_01    = 10'b0010101011;
    localparam logic [9:0] CTRL_10    = 10'b0101010100;
    localparam logic [9:0] CTRL_11    = 10'b1010101011;
    localparam logic [9:0] CLOCK_WORD = 10'b0000011111;

    typedef logic signed [4:0] disp_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// Single TMDS lane: stage 1 builds the transition-minimised q_m, stage 2 applies
// DC balancing against the lane's running disparity or emits a control token.
module tmds_lane_enc
    import tmds_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_blank,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_word
);

    logic [3:0] w_d_ones;
    logic       w_use_xnor;
    logic [8:0] w_qm;

    logic [8:0] r_qm;
    logic       r_blank;
    logic [1:0] r_ctrl;

    logic [3:0] w_q_ones;
    logic [3:0] w_q_zeros;
    disp_t      w_bal;
    disp_t      w_cnt_next;
    logic [9:0] w_word_next;

    logic [9:0] r_word;
    disp_t      r_cnt;

    always_comb begin
        w_d_ones   = popcount8(i_data);
        w_use_xnor = (w_d_ones > 4'd4) || ((w_d_ones == 4'd4) && !i_data[0]);
        w_qm       = '0;
        w_qm[0]    = i_data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        end
        w_qm[8] = ~w_use_xnor;
    end

    // Blank resets to 1 so the pipeline drains control token 00 while filling.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_qm    <= '0;
            r_blank <= 1'b1;
            r_ctrl  <= '0;
        end else begin
            r_qm    <= w_qm;
            r_blank <= i_blank;
            r_ctrl  <= i_ctrl;
        end
    end

    always_comb begin
        w_q_ones    = popcount8(r_qm[7:0]);
        w_q_zeros   = 4'd8 - w_q_ones;
        w_bal       = disp_t'({1'b0, w_q_ones}) - disp_t'({1'b0, w_q_zeros});
        w_word_next = CTRL_00;
        w_cnt_next  = '0;
        if (r_blank) begin
            w_word_next = ctrl_token(r_ctrl);
            w_cnt_next  = '0;
        end else if ((r_cnt == 5'sd0) || (w_q_ones == w_q_zeros)) begin
            w_word_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_next  = r_cnt + (r_qm[8] ? w_bal : -w_bal);
        end else if (((r_cnt > 5'sd0) && (w_q_ones > w_q_zeros)) ||
                     ((r_cnt < 5'sd0) && (w_q_zeros > w_q_ones))) begin
            w_word_next = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next  = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_bal;
        end else begin
            w_word_next = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next  = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_bal;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word <= CTRL_00;
            r_cnt  <= '0;
        end else begin
            r_word <= w_word_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// Pipelined three-lane DVI/TMDS encoder with depth expansion and fixed latency 2+C_out_reg.
// Define TMDS_CTL_EN to drive the green/red control tokens from in_ctl (HDMI preambles).
module tmds_encoder_pipe
    import tmds_pkg::*;
#(
    parameter int unsigned C_depth   = 8,
    parameter int unsigned C_out_reg = 1
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic [C_depth-1:0] in_red,
    input  logic [C_depth-1:0] in_green,
    input  logic [C_depth-1:0] in_blue,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_blank,
    input  logic [3:0]         in_ctl,
    output logic [9:0]         out_red,
    output logic [9:0]         out_green,
    output logic [9:0]         out_blue,
    output logic [9:0]         out_clock,
    output logic               out_valid
);

    localparam int unsigned L = 2 + C_out_reg;

    logic [7:0] w_red8;
    logic [7:0] w_green8;
    logic [7:0] w_blue8;
    logic [1:0] w_green_ctrl;
    logic [1:0] w_red_ctrl;
    logic [9:0] w_red_word;
    logic [9:0] w_green_word;
    logic [9:0] w_blue_word;
    logic [L-1:0] r_valid_sr;

    // Left-justify, then refill the low bits by repeating the input from its MSB.
    for (genvar i = 0; i < 8; i++) begin : g_expand
        assign w_red8[7-i]   = in_red[C_depth-1-(i % C_depth)];
        assign w_green8[7-i] = in_green[C_depth-1-(i % C_depth)];
        assign w_blue8[7-i]  = in_blue[C_depth-1-(i % C_depth)];
    end

`ifdef TMDS_CTL_EN
    assign w_green_ctrl = in_ctl[1:0];
    assign w_red_ctrl   = in_ctl[3:2];
`else
    logic w_unused_ctl;
    assign w_unused_ctl = ^in_ctl;
    assign w_green_ctrl = 2'b00;
    assign w_red_ctrl   = 2'b00;
`endif

    tmds_lane_enc u_red (
        .i_clk   (clk_pixel),
        .i_reset (reset),
        .i_data  (w_red8),
        .i_blank (in_blank),
        .i_ctrl  (w_red_ctrl),
        .o_word  (w_red_word)
    );

    tmds_lane_enc u_green (
        .i_clk   (clk_pixel),
        .i_reset (reset),
        .i_data  (w_green8),
        .i_blank (in_blank),
        .i_ctrl  (w_green_ctrl),
        .o_word  (w_green_word)
    );

    tmds_lane_enc u_blue (
        .i_clk   (clk_pixel),
        .i_reset (reset),
        .i_data  (w_blue8),
        .i_blank (in_blank),
        .i_ctrl  ({in_vsync, in_hsync}),
        .o_word  (w_blue_word)
    );

    if (C_out_reg != 0) begin : g_out_reg
        logic [9:0] r_red;
        logic [9:0] r_green;
        logic [9:0] r_blue;

        always_ff @(posedge clk_pixel) begin
            if (reset) begin
                r_red   <= CTRL_00;
                r_green <= CTRL_00;
                r_blue  <= CTRL_00;
            end else begin
                r_red   <= w_red_word;
                r_green <= w_green_word;
                r_blue  <= w_blue_word;
            end
        end

        assign out_red   = r_red;
        assign out_green = r_green;
        assign out_blue  = r_blue;
    end else begin : g_no_out_reg
        assign out_red   = w_red_word;
        assign out_green = w_green_word;
        assign out_blue  = w_blue_word;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_valid_sr <= '0;
        end else begin
            r_valid_sr <= {r_valid_sr[L-2:0], 1'b1};
        end
    end

    assign out_valid = r_valid_sr[L-1];
    assign out_clock = CLOCK_WORD;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Scoreboard bench for tmds_encoder_pipe: depth-8/latency-3 and depth-2/latency-2 instances
// share one random stimulus stream and are checked against a DVI-rule reference model.
module tb_tmds_encoder_pipe;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r8 = '0, g8 = '0, b8 = '0;
    logic [1:0] r2 = '0, g2 = '0, b2 = '0;
    logic       hs = 1'b0, vs = 1'b0, bl = 1'b0;
    logic [3:0] ctl = '0;

    logic [9:0] a_r, a_g, a_b, a_c;
    logic       a_v;
    logic [9:0] c_r, c_g, c_b, c_c;
    logic       c_v;

    exp_t        q [2][$];
    int          cnt_m [2][3];
    int          since [2];
    int unsigned lat [2] = '{3, 2};
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    tmds_encoder_pipe #(.C_depth(8), .C_out_reg(1)) dut8 (
        .clk_pixel(clk), .reset(rst),
        .in_red(r8), .in_green(g8), .in_blue(b8),
        .in_hsync(hs), .in_vsync(vs), .in_blank(bl), .in_ctl(ctl),
        .out_red(a_r), .out_green(a_g), .out_blue(a_b), .out_clock(a_c), .out_valid(a_v)
    );

    tmds_encoder_pipe #(.C_depth(2), .C_out_reg(0)) dut2 (
        .clk_pixel(clk), .reset(rst),
        .in_red(r2), .in_green(g2), .in_blue(b2),
        .in_hsync(hs), .in_vsync(vs), .in_blank(bl), .in_ctl(ctl),
        .out_red(c_r), .out_green(c_g), .out_blue(c_b), .out_clock(c_c), .out_valid(c_v)
    );

    function automatic logic [7:0] expand(input logic [7:0] v, input int depth);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = v[depth-1-(i % depth)];
        return e;
    endfunction

    function automatic logic [9:0] tok(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] d, input int cin, output int cout);
        logic [8:0] qm;
        logic [9:0] w;
        int  n1 = $countones(d);
        bit  xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        int  a, b, q8;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        q8 = xn ? 0 : 1;
        a  = $countones(qm[7:0]);
        b  = 8 - a;
        if (cin == 0 || a == b) begin
            w    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (q8 == 1 ? a - b : b - a);
        end else if ((cin > 0 && a > b) || (cin < 0 && b > a)) begin
            w    = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * q8 + (b - a);
        end else begin
            w    = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * (1 - q8) + (a - b);
        end
        return w;
    endfunction

    task automatic push(input int k, input logic [7:0] rd, input logic [7:0] gd,
                        input logic [7:0] bd, input int depth);
        exp_t e;
        int   nc;
        if (bl) begin
            e.b = tok({vs, hs});
`ifdef TMDS_CTL_EN
            e.g = tok(ctl[1:0]);
            e.r = tok(ctl[3:2]);
`else
            e.g = 10'h354;
            e.r = 10'h354;
`endif
            for (int j = 0; j < 3; j++) cnt_m[k][j] = 0;
        end else begin
            e.r = enc(expand(rd, depth), cnt_m[k][0], nc); cnt_m[k][0] = nc;
            e.g = enc(expand(gd, depth), cnt_m[k][1], nc); cnt_m[k][1] = nc;
            e.b = enc(expand(bd, depth), cnt_m[k][2], nc); cnt_m[k][2] = nc;
        end
        q[k].push_back(e);
    endtask

    // Inputs are set by the caller at a negedge and held through the following posedge.
    task automatic step(input bit r);
        rst = r;
        if (r) begin
            q[0].delete();
            q[1].delete();
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 3; j++) cnt_m[k][j] = 0;
        end else begin
            push(0, r8, g8, b8, 8);
            push(1, {6'b0, r2}, {6'b0, g2}, {6'b0, b2}, 2);
        end
        @(negedge clk);
    endtask

    task automatic cmp(input string name, input int k, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic check(input int k, input logic [9:0] r, input logic [9:0] g,
                         input logic [9:0] b, input logic [9:0] c, input logic v);
        bit   ev;
        exp_t e;
        if (rst) since[k] = 0;
        else since[k]++;
        ev = (since[k] >= int'(lat[k]));
        cmp("valid", k, {9'b0, v}, {9'b0, ev});
        cmp("clock", k, c, 10'b0000011111);
        if (!ev) begin
            cmp("idle_red", k, r, 10'h354);
            cmp("idle_green", k, g, 10'h354);
            cmp("idle_blue", k, b, 10'h354);
        end else if (q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL underflow dut%0d @%0t: output valid with no pixel expected", k, $time);
        end else begin
            e = q[k].pop_front();
            cmp("red", k, r, e.r);
            cmp("green", k, g, e.g);
            cmp("blue", k, b, e.b);
        end
    endtask

    initial begin
        since[0] = 0;
        since[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            check(0, a_r, a_g, a_b, a_c, a_v);
            check(1, c_r, c_g, c_b, c_c, c_v);
        end
    end

    initial begin
        @(negedge clk);
        repeat (3) step(1'b1);

        // Constant zero data: blue/green/red walk 0x100, 0x3FF, 0x100, 0x3FF ...
        r8 = '0; g8 = '0; b8 = '0; r2 = '0; g2 = '0; b2 = '0;
        repeat (8) step(1'b0);

        // Control period, every sync combination, then back to data.
        bl = 1'b1;
        ctl = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            {vs, hs} = 2'(s);
            step(1'b0);
        end
        bl = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (4) step(1'b0);

        // Depth expansion: 2'b10 must encode like 8'hAA.
        r8 = 8'hAA; r2 = 2'b10; g2 = 2'b01; b2 = 2'b11;
        repeat (6) step(1'b0);

        for (int i = 0; i < 10000; i++) begin
            r8  = 8'($urandom); g8 = 8'($urandom); b8 = 8'($urandom);
            r2  = 2'($urandom); g2 = 2'($urandom); b2 = 2'($urandom);
            bl  = ($urandom_range(0, 7) == 0);
            hs  = 1'($urandom); vs = 1'($urandom);
            ctl = 4'($urandom);
            step(i == 3000 || i == 7000);
        end

        bl = 1'b0;
        repeat (5) step(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_pipe.md
Name: tmds_encoder_pipe

Overview:
- Parametrised, pipelined single-clock DVI/TMDS encoder for the pixel domain of the video output path.
- Takes VGA-style RGB at a configurable colour depth plus sync/blank, and emits three DC-balanced 10-bit TMDS words per pixel plus the clock-lane word.
- Feeds the existing SDR/DDR serialiser and fake-differential output stage.
- Supersedes the fixed-depth encoder: adds generic depth expansion, a defined pipeline latency, per-lane disparity tracking and an optional HDMI control-period channel.

Parameters:
- C_depth, 8, input bits per colour, legal 1..8.
- C_out_reg, 1, 1 = extra output register stage (latency 3), 0 = latency 2.

Ports:
- clk_pixel  in  1  pixel clock; sole clock domain.
- reset  in  1  synchronous, active-high.
- in_red  in  C_depth  red, MSB-first.
- in_green  in  C_depth  green.
- in_blue  in  C_depth  blue.
- in_hsync  in  1  horizontal sync.
- in_vsync  in  1  vertical sync.
- in_blank  in  1  1 = control period.
- in_ctl  in  4  CTL3..0 for HDMI preambles; ignored unless TMDS_CTL_EN.
- out_red  out  10  TMDS word, bit 0 transmitted first.
- out_green  out  10  TMDS word.
- out_blue  out  10  TMDS word.
- out_clock  out  10  constant 10'b0000011111.
- out_valid  out  1  1 once the pipeline is filled after reset.

Behaviour:
- One clock, clk_pixel. Reset is synchronous and active-high.
- Reset values:
  - All three lane outputs = 10'b1101010100 (control token C1C0 = 00).
  - Disparity counters = 0.
  - out_valid = 0, rising L cycles after reset is released.
  - out_clock is constant and unaffected by reset.
- Latency L = 2 + C_out_reg cycles, identical for data and control. Sync/blank are pipelined alongside the data. There is no stall and no backpressure; one word is produced per clock.
- Depth expansion: left-justify the input into 8 bits, then fill the lower bits by repeating the input pattern from its MSB. Examples: depth 2 'b10 -> 8'hAA; depth 1 '1' -> 8'hFF; depth 8 passes through unchanged.
- Stage 1 registers the expanded data d and computes n1 = popcount(d).
- Stage 1 builds q_m:
  - XNOR chain if n1>4, or if n1==4 and d[0]==0; otherwise XOR chain.
  - q_m[0] = d[0].
  - q_m[8] = 1 for XOR, 0 for XNOR.
- Stage 2 uses a per-lane signed 5-bit disparity counter cnt (range -10..+10); n1/n0 are counted over q_m[7:0].
  - If cnt==0 or n1==n0: q_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1): q_out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (n0-n1).
  - Else: q_out = {0, q_m[8], q_m[7:0]}. cnt += -2*(~q_m[8]) + (n1-n0).
- Blank (as registered in the stage-1 sync/blank pipeline): each lane emits a control token and its cnt is cleared to 0.
  - Token map, {C1,C0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - Blue lane: {C1,C0} = {vsync, hsync}.
  - Green lane: {CTL1, CTL0}.
  - Red lane: {CTL3, CTL2}.
- Reset asserted mid-line: on the next edge all pipeline registers reload their reset values and in-flight pixels are discarded. No partial word is ever emitted.

Optional Feature:
- Macro TMDS_CTL_EN.
- Defined: in_ctl is registered with sync and drives the green and red control tokens, enabling HDMI preamble generation.
- Undefined: in_ctl is unused and the green/red tokens are fixed at 00. The port remains present so instantiations stay stable.

Decomposition:
- Package tmds_pkg holds:
  - the four control-token constants and CLOCK_WORD = 10'b0000011111;
  - the disparity type (signed [4:0]);
  - a popcount8 function.
- One sub-module, tmds_lane_enc: a single-lane two-stage encoder with its own cnt, instantiated three times.
- Depth expansion and control muxing stay in the top of this block.

Test Plan:
- Reset: hold reset for 3 cycles -> all lanes 10'b1101010100, out_valid=0; out_valid=1 exactly L cycles after release.
- Constant 8'h00 data, depth 8, blank=0:
  - lane words 0x100, 0x3FF, 0x100, 0x3FF;
  - internal cnt -8, +2, -6, +4;
  - first word appears L cycles after the first pixel.
- Control period: blank=1 with (vsync,hsync) = 00/01/10/11 -> blue emits 0x354/0x0AB/0x154/0x2AB; green and red emit 0x354; cnt reads 0 on return to data.
- Depth: C_depth=2, red='b10 -> stage-1 expanded byte 8'hAA; the encoded word equals the C_depth=8 encoding of 8'hAA.
- Reset mid-line: pseudo-random pixels, assert reset for 1 cycle -> next output is the reset token, no residual data, cnt=0. After a random run of 10 000 pixels, |cnt| <= 10 always holds.
- TMDS_CTL_EN defined, blank=1, in_ctl=4'b0101 -> green 0x0AB, red 0x0AB. With the macro undefined, the same stimulus gives green 0x354, red 0x354.
